// File: rtl/da_fir_pkg.sv
// Shared widths, FSM state encoding and the LUT sign-extension helper
// for the distributed-arithmetic FIR engine.
package da_fir_pkg;

    localparam int DATA_W = 16;              // input sample width, two's complement
    localparam int TAPS   = 8;               // number of taps == LUT address width
    localparam int LUT_W  = 32;              // LUT data width, two's complement
    localparam int ACC_W  = 48;              // accumulator / result width
    localparam int CNT_W  = $clog2(DATA_W);  // bit-plane counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Sign-extend one LUT partial sum to accumulator precision.
    function automatic logic [ACC_W-1:0] sext_lut(input logic [LUT_W-1:0] d);
        return {{(ACC_W - LUT_W){d[LUT_W-1]}}, d};
    endfunction

endpackage

// File: rtl/da_fir_engine_if.sv
// Bundle of the sample-in stream, result-out stream and LUT access port.
// The engine uses the slave view; the source/consumer/LUT side uses master.
interface da_fir_engine_if;
    import da_fir_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sample;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [TAPS-1:0]   lut_addr;
    logic [LUT_W-1:0]  lut_data;

    modport slave (
        input  in_valid, in_sample, out_ready, lut_data,
        output in_ready, out_valid, out_data, lut_addr
    );

    modport master (
        output in_valid, in_sample, out_ready, lut_data,
        input  in_ready, out_valid, out_data, lut_addr
    );

endinterface

// File: rtl/da_tap_line.sv
// TAPS-deep sample delay line plus the bit-plane extractor that turns
// bit `cnt` of every tap into one LUT address.
module da_tap_line
    import da_fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              plane_en,
    input  logic [DATA_W-1:0] sample,
    input  logic [CNT_W-1:0]  cnt,
    output logic [TAPS-1:0]   plane
);

    logic [DATA_W-1:0] taps [TAPS];

    // Shift a new sample into tap0 on acceptance; the oldest tap falls off.
    // NOTE: the delay line is a register array with an explicit reset, because
    // a zero history after reset is visible in the first filter outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) taps[k] <= '0;
        end else if (shift_en) begin
            taps[0] <= sample;
            for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
        end
    end

    // Collect bit `cnt` of each tap; the address is held at zero outside CALC.
    always_comb begin
        // NOTE: default first so every path assigns plane and no latch is inferred.
        plane = '0;
        if (plane_en) begin
            for (int k = 0; k < TAPS; k++) plane[k] = taps[k][cnt];
        end
    end

endmodule

// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic FIR engine: walks the sample bit-planes
// MSB-first, looks up the coefficient sum per plane and shift-accumulates.
module da_fir_engine
    import da_fir_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    da_fir_engine_if.slave  bus
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  lut_ext;
    logic [ACC_W-1:0]  out_q;
    logic              accept;
    logic              calc_en;

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

    assign accept  = (state == IDLE) && bus.in_valid;
    assign lut_ext = sext_lut(bus.lut_data);

    // The sign plane carries negative weight, so it seeds the accumulator
    // with the negated partial sum; later planes shift left and add.
    assign acc_next = (cnt == CNT_TOP) ? (ACC_W'(0) - lut_ext)
                                       : ((acc << 1) + lut_ext);

    assign bus.out_data = out_q;

    da_tap_line u_tap_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .plane_en (calc_en),
        .sample   (bus.in_sample),
        .cnt      (cnt),
        .plane    (bus.lut_addr)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: accept -> DATA_W plane cycles -> hold result until taken.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_next = CALC;
            CALC:    if (cnt == '0)     state_next = OUT;
            OUT:     if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Output decode from the registered state; in_ready is also held low in reset.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        calc_en       = 1'b0;
        unique case (state)
            IDLE:    bus.in_ready  = rst_n;
            CALC:    calc_en       = 1'b1;
            OUT:     bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Plane counter, accumulator and result register; the result is captured
    // on the last plane so it survives the next computation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            out_q <= '0;
        end else if (accept) begin
            cnt <= CNT_TOP;
        end else if (calc_en) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc_next;
            if (cnt == '0) out_q <= acc_next;
        end
    end

endmodule

// File: tb/tb_da_fir_engine.sv
// Scoreboard bench for da_fir_engine: a coefficient-sum LUT model, a
// direct-form convolution reference model and a monitor that checks every
// result handshake, every CALC address and acceptance timing.
module tb_da_fir_engine;
    import da_fir_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    da_fir_engine_if bus();

    da_fir_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int coef [TAPS] = '{1, 1, -5, -12, 22, 39, -62, -94};

    // LUT model: sum of the coefficients whose address bit is set.
    logic signed [LUT_W-1:0] lut_sum;
    always_comb begin
        lut_sum = '0;
        for (int k = 0; k < TAPS; k++)
            if (bus.lut_addr[k]) lut_sum = lut_sum + LUT_W'(coef[k]);
        bus.lut_data = lut_sum;
    end

    // out_ready is either forced by the stimulus or randomised.
    logic ready_force = 1'b1;
    logic rand_ready  = 1'b0;
    logic rnd_ready   = 1'b1;
    always @(posedge clk) begin
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end
    assign bus.out_ready = rand_ready ? rnd_ready : ready_force;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state, owned by the monitor.
    longint           hist [TAPS];
    logic [ACC_W-1:0] exp_q [$];
    int               acc_cyc  = -1;
    int               prev_acc = -1;
    bit               tput_mode = 1'b0;
    int               rel_m;
    bit               in_calc;

    function automatic logic [ACC_W-1:0] model_y();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(coef[k]) * hist[k];
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [TAPS-1:0] model_plane(input int j);
        logic [TAPS-1:0] p;
        logic [63:0]     h;
        for (int k = 0; k < TAPS; k++) begin
            h    = hist[k];
            p[k] = h[j];
        end
        return p;
    endfunction

    // Monitor: CALC address/timing checks, scoreboard pops, model updates.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) hist[k] = 0;
            exp_q.delete();
            acc_cyc  = -1;
            prev_acc = -1;
        end else begin
            if (!tput_mode) prev_acc = -1;
            in_calc = 1'b0;
            if (acc_cyc >= 0) begin
                rel_m = cyc - acc_cyc;
                if (rel_m < DATA_W) begin
                    in_calc = 1'b1;
                    check("lut_addr_plane", bus.lut_addr, model_plane(DATA_W - 1 - rel_m));
                    check("in_ready_calc", bus.in_ready, 0);
                end else begin
                    check("latency_out_valid", bus.out_valid, 1);
                    acc_cyc = -1;
                end
            end
            if (!in_calc) check("lut_addr_zero", bus.lut_addr, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", bus.out_valid, 0);
                else                   check("out_data", bus.out_data, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = longint'($signed(bus.in_sample));
                exp_q.push_back(model_y());
                if (tput_mode && prev_acc >= 0)
                    check("accept_interval", cyc + 1 - prev_acc, DATA_W + 2);
                prev_acc = cyc + 1;
                acc_cyc  = cyc + 1;
            end
        end
    end

    // Offer one sample and wait (bounded) for the acceptance edge.
    task automatic send(input logic [DATA_W-1:0] x, input bit hold);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_sample = x;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [ACC_W-1:0] v);
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        v = bus.out_data;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", bus.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACC_W-1:0] v;
        logic [ACC_W-1:0] v0;
        logic [ACC_W-1:0] e;

        bus.in_valid  = 1'b0;
        bus.in_sample = '0;

        // Reset state
        #12;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_lut_addr", bus.lut_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Impulse response followed by a ninth zero
        send(16'd1, 1'b0);
        repeat (8) send(16'd0, 1'b0);
        wait_drain();

        // Negative full scale on tap0 then tap1
        apply_reset();
        send(16'h8000, 1'b0);
        wait_out(v);
        e = 48'hFFFF_FFFF_8000;
        check("neg_full_scale", v, e);
        @(posedge clk);
        #1;
        send(16'd0, 1'b0);
        wait_out(v);
        check("neg_full_scale_tap1", v, e);
        @(posedge clk);
        #1;
        wait_drain();

        // DC maximum through all eight taps
        apply_reset();
        repeat (8) send(16'd32767, 1'b0);
        wait_out(v);
        e = -48'sd3604370;
        check("dc_max", v, e);
        @(posedge clk);
        #1;
        wait_drain();

        // Backpressure: result held, input ignored while in OUT
        ready_force = 1'b0;
        send(16'd300, 1'b0);
        wait_out(v0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = (i % 2 == 0);
            bus.in_sample = 16'($urandom);
            @(negedge clk);
            check("bp_out_data_stable", bus.out_data, v0);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_force  = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_out_valid", bus.out_valid, 0);
        check("bp_out_data_kept", bus.out_data, v0);
        @(posedge clk);
        #1;

        // Reset in the middle of CALC (cnt = 7)
        send(16'h1234, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_lut_addr", bus.lut_addr, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'd1, 1'b0);
        wait_out(v);
        e = 48'd1;
        check("impulse_after_reset", v, e);
        @(posedge clk);
        #1;
        wait_drain();

        // Throughput with in_valid and out_ready held high
        tput_mode = 1'b1;
        for (int i = 0; i < 10; i++) send(16'($urandom), 1'b1);
        bus.in_valid = 1'b0;
        wait_drain();
        tput_mode = 1'b0;

        // Random samples with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(16'($urandom), 1'b0);
        wait_drain();
        rand_ready = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
